// File: rtl/seq_ctrl_pkg.sv
// Shared constants for the accumulator-CPU sequencer: ctrl bus layout, ALU codes,
// opcodes, step numbering and the decode record passed from seq_decode to seq_control.
package seq_ctrl_pkg;

    // ctrl bus bit positions, MSB first
    localparam int CW          = 19;
    localparam int CB_ARLOAD   = 18;
    localparam int CB_ARINC    = 17;
    localparam int CB_PCLOAD   = 16;
    localparam int CB_PCINC    = 15;
    localparam int CB_DRLOAD   = 14;
    localparam int CB_IRLOAD   = 13;
    localparam int CB_TRLOAD   = 12;
    localparam int CB_RLOAD    = 11;
    localparam int CB_ACLOAD   = 10;
    localparam int CB_ZLOAD    = 9;
    localparam int CB_ACLOADR  = 8;
    localparam int CB_PCBUS    = 7;
    localparam int CB_DRBUSD   = 6;
    localparam int CB_DRBUSA   = 5;
    localparam int CB_TRBUS    = 4;
    localparam int CB_RBUS     = 3;
    localparam int CB_ACBUS    = 2;
    localparam int CB_MEMRD    = 1;
    localparam int CB_MEMWR    = 0;

    localparam logic [3:0] ALU_CLAC = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_INAC = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NOT  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_PASS = 4'b1000;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LDAC  = 8'h01;
    localparam logic [7:0] OP_STAC  = 8'h02;
    localparam logic [7:0] OP_MOVAC = 8'h03;
    localparam logic [7:0] OP_MOVR  = 8'h04;
    localparam logic [7:0] OP_JUMP  = 8'h05;
    localparam logic [7:0] OP_JMPZ  = 8'h06;
    localparam logic [7:0] OP_JPNZ  = 8'h07;
    localparam logic [7:0] OP_ADD   = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_INAC  = 8'h0A;
    localparam logic [7:0] OP_CLAC  = 8'h0B;
    localparam logic [7:0] OP_AND   = 8'h0C;
    localparam logic [7:0] OP_OR    = 8'h0D;
    localparam logic [7:0] OP_XOR   = 8'h0E;
    localparam logic [7:0] OP_NOT   = 8'h0F;
    localparam logic [3:0] OP_MOVR_N  = 4'h1;
    localparam logic [3:0] OP_MOVAC_N = 4'h2;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [3:0] S_F1 = 4'd0;
    localparam logic [3:0] S_F2 = 4'd1;
    localparam logic [3:0] S_F3 = 4'd2;
    localparam logic [3:0] S_E1 = 4'd3;
    localparam logic [3:0] S_E2 = 4'd4;
    localparam logic [3:0] S_E3 = 4'd5;
    localparam logic [3:0] S_E4 = 4'd6;
    localparam logic [3:0] S_E5 = 4'd7;
    localparam logic [3:0] S_E6 = 4'd8;

    // one-hot instruction classes
    localparam int OPC_NOP   = 0;
    localparam int OPC_LDAC  = 1;
    localparam int OPC_STAC  = 2;
    localparam int OPC_MOVAC = 3;
    localparam int OPC_MOVR  = 4;
    localparam int OPC_JUMP  = 5;
    localparam int OPC_JMPZ  = 6;
    localparam int OPC_JPNZ  = 7;
    localparam int OPC_ALU   = 8;
    localparam int OPC_HALT  = 9;
    localparam int NOPC      = 10;

    typedef logic [NOPC-1:0] op_vec_t;

    typedef struct packed {
        op_vec_t    op;
        logic [3:0] alus;
        logic [3:0] last;
        logic       illegal;
    } dec_t;

    function automatic int rsw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: IR byte -> instruction class, ALU op,
// register select, final execute step and illegal flag.
module seq_decode
    import seq_ctrl_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic [7:0]              instr,
    output dec_t                    dec,
    output logic [rsw_of(NREG)-1:0] rsel
);

    localparam int RSW = rsw_of(NREG);

    logic [3:0] lo;
    logic       reg_ok;

    assign lo     = instr[3:0];
    assign reg_ok = ({28'd0, lo} < 32'(NREG));

    always_comb begin
        dec         = '0;
        dec.alus    = ALU_PASS;
        dec.last    = S_E1;
        rsel        = '0;
        case (instr)
            OP_NOP:   dec.op[OPC_NOP] = 1'b1;
            OP_LDAC: begin
                dec.op[OPC_LDAC] = 1'b1;
                dec.last         = S_E6;
            end
            OP_STAC: begin
                dec.op[OPC_STAC] = 1'b1;
                dec.last         = S_E5;
            end
            OP_MOVAC: dec.op[OPC_MOVAC] = 1'b1;
            OP_MOVR:  dec.op[OPC_MOVR]  = 1'b1;
            OP_JUMP: begin
                dec.op[OPC_JUMP] = 1'b1;
                dec.last         = S_E3;
            end
            OP_JMPZ: begin
                dec.op[OPC_JMPZ] = 1'b1;
                dec.last         = S_E3;
            end
            OP_JPNZ: begin
                dec.op[OPC_JPNZ] = 1'b1;
                dec.last         = S_E3;
            end
            OP_ADD, OP_SUB, OP_INAC, OP_CLAC, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                dec.op[OPC_ALU] = 1'b1;
                dec.last        = S_E2;
                case (instr)
                    OP_ADD:  dec.alus = ALU_ADD;
                    OP_SUB:  dec.alus = ALU_SUB;
                    OP_INAC: dec.alus = ALU_INAC;
                    OP_CLAC: dec.alus = ALU_CLAC;
                    OP_AND:  dec.alus = ALU_AND;
                    OP_OR:   dec.alus = ALU_OR;
                    OP_XOR:  dec.alus = ALU_XOR;
                    default: dec.alus = ALU_NOT;
                endcase
            end
            OP_HALT:  dec.op[OPC_HALT] = 1'b1;
            default: begin
                if (instr[7:4] == OP_MOVR_N && reg_ok) begin
                    dec.op[OPC_MOVR] = 1'b1;
                    rsel             = RSW'(lo);
                end else if (instr[7:4] == OP_MOVAC_N && reg_ok) begin
                    dec.op[OPC_MOVAC] = 1'b1;
                    rsel              = RSW'(lo);
                end else begin
                    // undefined codes retire as a NOP after flagging
                    dec.op[OPC_NOP] = 1'b1;
                    dec.illegal     = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/seq_control.sv
// Hardwired sequencer: binary step counter over fetch/execute, wait-state and
// run/halt qualification, and the ctrl strobe equations for the datapath.
module seq_control
    import seq_ctrl_pkg::*;
#(
    parameter int         NREG    = 4,
    parameter bit         WAIT_EN = 1'b1,
    parameter logic [1:0] RUN_ST  = 2'b11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              instr,
    input  logic                    Z,
    input  logic [1:0]              CPUstate,
    input  logic                    mem_ack,
    output logic [CW-1:0]           ctrl,
    output logic [3:0]              alus,
    output logic [rsw_of(NREG)-1:0] rsel,
    output logic [3:0]              step,
    output logic                    clr,
    output logic                    halted,
    output logic                    illegal
);

    logic [3:0]    step_reg, step_next;
    logic          halted_reg, halted_next;
    dec_t          dec;
    logic [CW-1:0] raw_ctrl;
    logic          mem_step;
    logic          run, ack, step_ack;
    logic          in_exec, bad_step, final_step;
    logic          jump_any, taken;

    seq_decode #(.NREG(NREG)) u_decode (
        .instr (instr),
        .dec   (dec),
        .rsel  (rsel)
    );

    assign run      = (CPUstate == RUN_ST) && !halted_reg;
    assign ack      = !WAIT_EN || mem_ack;
    assign step_ack = !mem_step || ack;
    assign in_exec  = (step_reg >= S_E1) && (step_reg <= S_E6);
    assign bad_step = (step_reg > S_E6);
    assign final_step = bad_step || (in_exec && (step_reg >= dec.last));

    assign jump_any = dec.op[OPC_JUMP] || dec.op[OPC_JMPZ] || dec.op[OPC_JPNZ];
    assign taken    = dec.op[OPC_JUMP] || (dec.op[OPC_JMPZ] && Z) || (dec.op[OPC_JPNZ] && !Z);

    // Ungated strobes for the current step; mem_step marks steps that wait on mem_ack
    always_comb begin
        raw_ctrl = '0;
        mem_step = 1'b0;
        case (step_reg)
            S_F1: begin
                raw_ctrl[CB_PCBUS]  = 1'b1;
                raw_ctrl[CB_ARLOAD] = 1'b1;
            end
            S_F2: begin
                mem_step            = 1'b1;
                raw_ctrl[CB_MEMRD]  = 1'b1;
                raw_ctrl[CB_DRLOAD] = 1'b1;
                raw_ctrl[CB_PCINC]  = 1'b1;
            end
            S_F3: begin
                raw_ctrl[CB_PCBUS]  = 1'b1;
                raw_ctrl[CB_ARLOAD] = 1'b1;
                raw_ctrl[CB_IRLOAD] = 1'b1;
            end
            default: begin
                if (dec.op[OPC_LDAC] || dec.op[OPC_STAC]) begin
                    case (step_reg)
                        S_E1: begin
                            mem_step            = 1'b1;
                            raw_ctrl[CB_MEMRD]  = 1'b1;
                            raw_ctrl[CB_DRLOAD] = 1'b1;
                            raw_ctrl[CB_PCINC]  = 1'b1;
                            raw_ctrl[CB_ARINC]  = 1'b1;
                        end
                        S_E2: begin
                            mem_step            = 1'b1;
                            raw_ctrl[CB_MEMRD]  = 1'b1;
                            raw_ctrl[CB_TRLOAD] = 1'b1;
                            raw_ctrl[CB_DRLOAD] = 1'b1;
                            raw_ctrl[CB_PCINC]  = 1'b1;
                        end
                        S_E3: begin
                            raw_ctrl[CB_DRBUSA] = 1'b1;
                            raw_ctrl[CB_TRBUS]  = 1'b1;
                            raw_ctrl[CB_ARLOAD] = 1'b1;
                        end
                        S_E4: begin
                            raw_ctrl[CB_DRLOAD] = 1'b1;
                            if (dec.op[OPC_LDAC]) begin
                                mem_step           = 1'b1;
                                raw_ctrl[CB_MEMRD] = 1'b1;
                            end else begin
                                raw_ctrl[CB_ACBUS] = 1'b1;
                            end
                        end
                        S_E5: begin
                            raw_ctrl[CB_DRBUSD] = 1'b1;
                            if (dec.op[OPC_LDAC]) begin
                                raw_ctrl[CB_ACLOAD] = 1'b1;
                            end else begin
                                mem_step           = 1'b1;
                                raw_ctrl[CB_MEMWR] = 1'b1;
                            end
                        end
                        default: ;  // LDAC E6 is a strobe-free retire beat
                    endcase
                end else if (jump_any) begin
                    if (taken) begin
                        case (step_reg)
                            S_E1: begin
                                mem_step            = 1'b1;
                                raw_ctrl[CB_MEMRD]  = 1'b1;
                                raw_ctrl[CB_DRLOAD] = 1'b1;
                                raw_ctrl[CB_ARINC]  = 1'b1;
                            end
                            S_E2: begin
                                mem_step            = 1'b1;
                                raw_ctrl[CB_MEMRD]  = 1'b1;
                                raw_ctrl[CB_TRLOAD] = 1'b1;
                                raw_ctrl[CB_DRLOAD] = 1'b1;
                            end
                            S_E3: begin
                                raw_ctrl[CB_DRBUSA] = 1'b1;
                                raw_ctrl[CB_TRBUS]  = 1'b1;
                                raw_ctrl[CB_PCLOAD] = 1'b1;
                            end
                            default: ;
                        endcase
                    end else if (step_reg == S_E2 || step_reg == S_E3) begin
                        // not taken: step PC over the two address bytes
                        raw_ctrl[CB_PCINC] = 1'b1;
                    end
                end else if (dec.op[OPC_ALU]) begin
                    if (step_reg == S_E1) begin
                        raw_ctrl[CB_RBUS]   = 1'b1;
                        raw_ctrl[CB_TRLOAD] = 1'b1;
                    end else if (step_reg == S_E2) begin
                        raw_ctrl[CB_TRBUS]  = 1'b1;
                        raw_ctrl[CB_ACLOAD] = 1'b1;
                        raw_ctrl[CB_ZLOAD]  = 1'b1;
                    end
                end else if (dec.op[OPC_MOVR]) begin
                    raw_ctrl[CB_RBUS]    = 1'b1;
                    raw_ctrl[CB_ACLOADR] = 1'b1;
                    raw_ctrl[CB_ZLOAD]   = 1'b1;
                end else if (dec.op[OPC_MOVAC]) begin
                    raw_ctrl[CB_ACBUS] = 1'b1;
                    raw_ctrl[CB_RLOAD] = 1'b1;
                end else if (dec.op[OPC_NOP] || dec.op[OPC_HALT]) begin
                    // no datapath activity; HALT acts through halted_next
                end
                if (!in_exec) begin
                    raw_ctrl = '0;
                    mem_step = 1'b0;
                end
            end
        endcase
    end

    // Memory strobes cover the whole step; everything else waits for the ack
    genvar gi;
    generate
        for (gi = 0; gi < CW; gi++) begin : g_ctrl
            if (gi == CB_MEMRD || gi == CB_MEMWR) begin : g_mem
                assign ctrl[gi] = run && raw_ctrl[gi];
            end else begin : g_dp
                assign ctrl[gi] = run && raw_ctrl[gi] && step_ack;
            end
        end
    endgenerate

    assign clr     = run && final_step && step_ack;
    assign illegal = run && (step_reg == S_E1) && dec.illegal;
    assign alus    = in_exec ? dec.alus : ALU_PASS;
    assign step    = step_reg;
    assign halted  = halted_reg;

    always_comb begin
        step_next   = step_reg;
        halted_next = halted_reg;
        if (bad_step) begin
            step_next = S_F1;
        end else if (run && step_ack) begin
            step_next = final_step ? S_F1 : step_reg + 4'd1;
        end
        if (run && (step_reg == S_E1) && dec.op[OPC_HALT]) begin
            halted_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg   <= S_F1;
            halted_reg <= 1'b0;
        end else begin
            step_reg   <= step_next;
            halted_reg <= halted_next;
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// Directed bench for seq_control: walks hand-sequenced instructions cycle by cycle
// and compares step/ctrl/clr and the status outputs against fixed expectations.
module tb_seq_control;

    localparam logic [31:0] M_ARLOAD  = 32'h40000;
    localparam logic [31:0] M_ARINC   = 32'h20000;
    localparam logic [31:0] M_PCLOAD  = 32'h10000;
    localparam logic [31:0] M_PCINC   = 32'h08000;
    localparam logic [31:0] M_DRLOAD  = 32'h04000;
    localparam logic [31:0] M_IRLOAD  = 32'h02000;
    localparam logic [31:0] M_TRLOAD  = 32'h01000;
    localparam logic [31:0] M_RLOAD   = 32'h00800;
    localparam logic [31:0] M_ACLOAD  = 32'h00400;
    localparam logic [31:0] M_ZLOAD   = 32'h00200;
    localparam logic [31:0] M_ACLOADR = 32'h00100;
    localparam logic [31:0] M_PCBUS   = 32'h00080;
    localparam logic [31:0] M_DRBUSD  = 32'h00040;
    localparam logic [31:0] M_DRBUSA  = 32'h00020;
    localparam logic [31:0] M_TRBUS   = 32'h00010;
    localparam logic [31:0] M_RBUS    = 32'h00008;
    localparam logic [31:0] M_ACBUS   = 32'h00004;
    localparam logic [31:0] M_MEMRD   = 32'h00002;
    localparam logic [31:0] M_MEMWR   = 32'h00001;

    logic        clk = 1'b0;
    logic        rst, Z, mem_ack;
    logic [7:0]  instr;
    logic [1:0]  CPUstate;
    logic [18:0] ctrl;
    logic [3:0]  alus;
    logic [1:0]  rsel;
    logic [3:0]  step;
    logic        clr, halted, illegal;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0, pcinc_cnt = 0, drload_cnt = 0;
    int c0, p0, d0;

    always #5 clk = ~clk;

    seq_control #(.NREG(4), .WAIT_EN(1'b1), .RUN_ST(2'b11)) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .Z        (Z),
        .CPUstate (CPUstate),
        .mem_ack  (mem_ack),
        .ctrl     (ctrl),
        .alus     (alus),
        .rsel     (rsel),
        .step     (step),
        .clr      (clr),
        .halted   (halted),
        .illegal  (illegal)
    );

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (ctrl[15]) pcinc_cnt <= pcinc_cnt + 1;
        if (ctrl[14]) drload_cnt <= drload_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: apply mem_ack, check the current step, then move past the next edge
    task automatic cyc(input string tag, input logic ack, input logic [31:0] est,
                       input logic [31:0] ectl, input logic [31:0] eclr);
        mem_ack = ack;
        #1;
        check_eq({tag, ".step"}, 32'(step), est);
        check_eq({tag, ".ctrl"}, 32'(ctrl), ectl);
        check_eq({tag, ".clr"},  32'(clr),  eclr);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag);
        cyc({tag, ".F1"}, 1'b1, 0, M_PCBUS | M_ARLOAD, 0);
        cyc({tag, ".F2"}, 1'b1, 1, M_MEMRD | M_DRLOAD | M_PCINC, 0);
        cyc({tag, ".F3"}, 1'b1, 2, M_PCBUS | M_ARLOAD | M_IRLOAD, 0);
    endtask

    task automatic mark;
        c0 = cyc_cnt;
        p0 = pcinc_cnt;
        d0 = drload_cnt;
    endtask

    task automatic txn(input string tag);
        $display("txn %s instr=%02h cycles=%0d pcinc=%0d drload=%0d",
                 tag, instr, cyc_cnt - c0, pcinc_cnt - p0, drload_cnt - d0);
    endtask

    initial begin
        rst = 1'b1; instr = 8'h00; Z = 1'b0; CPUstate = 2'b11; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.step",    32'(step), 0);
        check_eq("rst.ctrl",    32'(ctrl), M_PCBUS | M_ARLOAD);
        check_eq("rst.halted",  32'(halted), 0);
        check_eq("rst.illegal", 32'(illegal), 0);
        rst = 1'b0;

        // NOP: four cycles, one PC increment
        instr = 8'h00; mark();
        fetch("nop");
        cyc("nop.E1", 1'b1, 3, 0, 1);
        check_eq("nop.cycles", 32'(cyc_cnt - c0), 4);
        check_eq("nop.pcinc",  32'(pcinc_cnt - p0), 1);
        txn("nop");

        // LDAC with two wait cycles in F2 and in E2
        instr = 8'h01; mark();
        cyc("ldac.F1", 1'b1, 0, M_PCBUS | M_ARLOAD, 0);
        cyc("ldac.F2w0", 1'b0, 1, M_MEMRD, 0);
        cyc("ldac.F2w1", 1'b0, 1, M_MEMRD, 0);
        cyc("ldac.F2", 1'b1, 1, M_MEMRD | M_DRLOAD | M_PCINC, 0);
        cyc("ldac.F3", 1'b1, 2, M_PCBUS | M_ARLOAD | M_IRLOAD, 0);
        cyc("ldac.E1", 1'b1, 3, M_MEMRD | M_DRLOAD | M_PCINC | M_ARINC, 0);
        cyc("ldac.E2w0", 1'b0, 4, M_MEMRD, 0);
        cyc("ldac.E2w1", 1'b0, 4, M_MEMRD, 0);
        cyc("ldac.E2", 1'b1, 4, M_MEMRD | M_TRLOAD | M_DRLOAD | M_PCINC, 0);
        cyc("ldac.E3", 1'b1, 5, M_DRBUSA | M_TRBUS | M_ARLOAD, 0);
        cyc("ldac.E4", 1'b1, 6, M_MEMRD | M_DRLOAD, 0);
        cyc("ldac.E5", 1'b1, 7, M_DRBUSD | M_ACLOAD, 0);
        cyc("ldac.E6", 1'b1, 8, 0, 1);
        check_eq("ldac.cycles", 32'(cyc_cnt - c0), 13);
        check_eq("ldac.pcinc",  32'(pcinc_cnt - p0), 3);
        check_eq("ldac.drload", 32'(drload_cnt - d0), 4);
        txn("ldac");

        // JMPZ taken
        instr = 8'h06; Z = 1'b1; mark();
        fetch("jmpz1");
        cyc("jmpz1.E1", 1'b1, 3, M_MEMRD | M_DRLOAD | M_ARINC, 0);
        cyc("jmpz1.E2", 1'b1, 4, M_MEMRD | M_TRLOAD | M_DRLOAD, 0);
        cyc("jmpz1.E3", 1'b1, 5, M_PCLOAD | M_DRBUSA | M_TRBUS, 1);
        txn("jmpz_taken");

        // JMPZ not taken
        instr = 8'h06; Z = 1'b0; mark();
        fetch("jmpz0");
        cyc("jmpz0.E1", 1'b1, 3, 0, 0);
        cyc("jmpz0.E2", 1'b1, 4, M_PCINC, 0);
        cyc("jmpz0.E3", 1'b1, 5, M_PCINC, 1);
        check_eq("jmpz0.pcinc", 32'(pcinc_cnt - p0), 3);
        txn("jmpz_not_taken");

        // ADD: two-step ALU op through TR
        instr = 8'h08; mark();
        fetch("add");
        check_eq("add.alus", 32'(alus), 32'h1);
        cyc("add.E1", 1'b1, 3, M_RBUS | M_TRLOAD, 0);
        cyc("add.E2", 1'b1, 4, M_TRBUS | M_ACLOAD | M_ZLOAD, 1);
        txn("add");

        // MOVR R2
        instr = 8'h12; mark();
        fetch("movr2");
        check_eq("movr2.rsel", 32'(rsel), 2);
        cyc("movr2.E1", 1'b1, 3, M_RBUS | M_ACLOADR | M_ZLOAD, 1);
        txn("movr_r2");

        // MOVAC R3
        instr = 8'h23; mark();
        fetch("movac3");
        check_eq("movac3.rsel", 32'(rsel), 3);
        cyc("movac3.E1", 1'b1, 3, M_ACBUS | M_RLOAD, 1);
        txn("movac_r3");

        // MOVR R5 is out of range for four registers
        instr = 8'h15; mark();
        fetch("ill");
        check_eq("ill.pulse", 32'(illegal), 1);
        cyc("ill.E1", 1'b1, 3, 0, 1);
        check_eq("ill.after", 32'(illegal), 0);
        txn("illegal_15");

        // STAC with a wait state on the write
        instr = 8'h02; mark();
        fetch("stac");
        cyc("stac.E1", 1'b1, 3, M_MEMRD | M_DRLOAD | M_PCINC | M_ARINC, 0);
        cyc("stac.E2", 1'b1, 4, M_MEMRD | M_TRLOAD | M_DRLOAD | M_PCINC, 0);
        cyc("stac.E3", 1'b1, 5, M_DRBUSA | M_TRBUS | M_ARLOAD, 0);
        cyc("stac.E4", 1'b1, 6, M_ACBUS | M_DRLOAD, 0);
        cyc("stac.E5w", 1'b0, 7, M_MEMWR, 0);
        cyc("stac.E5", 1'b1, 7, M_MEMWR | M_DRBUSD, 1);
        txn("stac");

        // pause in LDAC E3
        instr = 8'h01; mark();
        fetch("pause");
        cyc("pause.E1", 1'b1, 3, M_MEMRD | M_DRLOAD | M_PCINC | M_ARINC, 0);
        cyc("pause.E2", 1'b1, 4, M_MEMRD | M_TRLOAD | M_DRLOAD | M_PCINC, 0);
        CPUstate = 2'b00;
        for (int i = 0; i < 3; i++) cyc("pause.hold", 1'b1, 5, 0, 0);
        CPUstate = 2'b11;
        cyc("pause.E3", 1'b1, 5, M_DRBUSA | M_TRBUS | M_ARLOAD, 0);
        cyc("pause.E4", 1'b1, 6, M_MEMRD | M_DRLOAD, 0);
        cyc("pause.E5", 1'b1, 7, M_DRBUSD | M_ACLOAD, 0);
        cyc("pause.E6", 1'b1, 8, 0, 1);
        check_eq("pause.cycles", 32'(cyc_cnt - c0), 12);
        txn("ldac_paused");

        // reset in the middle of STAC
        instr = 8'h02; mark();
        fetch("srst");
        cyc("srst.E1", 1'b1, 3, M_MEMRD | M_DRLOAD | M_PCINC | M_ARINC, 0);
        cyc("srst.E2", 1'b1, 4, M_MEMRD | M_TRLOAD | M_DRLOAD | M_PCINC, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("srst.step",   32'(step), 0);
        check_eq("srst.halted", 32'(halted), 0);
        rst = 1'b0;
        txn("stac_reset");

        // HALT, then reset clears it
        instr = 8'hFF; mark();
        fetch("halt");
        cyc("halt.E1", 1'b1, 3, 0, 1);
        check_eq("halt.halted", 32'(halted), 1);
        cyc("halt.idle0", 1'b1, 0, 0, 0);
        cyc("halt.idle1", 1'b1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("halt.cleared", 32'(halted), 0);
        check_eq("halt.resume",  32'(ctrl), M_PCBUS | M_ARLOAD);
        txn("halt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
